// File: rtl/seq_pkg.sv
// Shared constants for the ROM sequencer: active-low seven-segment glyphs
// (dp off) and the table address-width helper.
package seq_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic int addr_w(input int st_w, input int in_w);
    return st_w + in_w;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Registered hex-to-seven-segment decoder; cathodes are active-low, dp held off.
module seg7_hex_decoder
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  always_ff @(posedge clk) begin
    case (hex)
      4'h0:    seg <= SEG_0;
      4'h1:    seg <= SEG_1;
      4'h2:    seg <= SEG_2;
      4'h3:    seg <= SEG_3;
      4'h4:    seg <= SEG_4;
      4'h5:    seg <= SEG_5;
      4'h6:    seg <= SEG_6;
      4'h7:    seg <= SEG_7;
      4'h8:    seg <= SEG_8;
      4'h9:    seg <= SEG_9;
      4'hA:    seg <= SEG_A;
      4'hB:    seg <= SEG_B;
      4'hC:    seg <= SEG_C;
      4'hD:    seg <= SEG_D;
      4'hE:    seg <= SEG_E;
      default: seg <= SEG_F;
    endcase
  end

endmodule

// File: rtl/rom_seq_engine.sv
// Table-driven sequencer: {state, inputs} addresses a writable table giving {Z, next_state}.
// Steps on prescaler ticks, either free-running or once per synchronised button press.
module rom_seq_engine
  import seq_pkg::*;
#(
  parameter int ST_W        = 2,
  parameter int IN_W        = 3,
  parameter int OUT_W       = 3,
  parameter int NUM_STATES  = 3,
  parameter int RESET_STATE = 0,
  parameter int DIV         = 50000000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_W-1:0]      X,
  input  logic                 PBC,
  input  logic                 MODE,
  input  logic                 WE,
  input  logic [ST_W+IN_W-1:0] WADDR,
  input  logic [OUT_W+ST_W-1:0] WDATA,
  output logic [ST_W-1:0]      STATE,
  output logic [OUT_W-1:0]     Z,
  output logic                 TICK_LED,
  output logic                 ERR,
  output logic [7:0]           SSEG_CA,
  output logic [7:0]           SSEG_AN
);

  localparam int AW = addr_w(ST_W, IN_W);
  localparam int DW = OUT_W + ST_W;
  localparam int PW = $clog2(DIV);

  logic [DW-1:0]   rom [2**AW];
  logic [DW-1:0]   word;
  logic [PW-1:0]   cnt;
  logic            tick;
  logic [IN_W-1:0] x_s1, x_s2;
  logic            pbc_s1, pbc_s2, pbc_s3;
  logic            pbc_edge;
  logic            pending;
  logic            step;
  logic            illegal;
  logic [ST_W-1:0] state_q;
  logic [OUT_W-1:0] z_q;
  logic            err_q;
  logic            tick_led;
  logic [ST_W+3:0] st_ext;
  logic [3:0]      nib;

  // The table image is loaded through WE/WADDR/WDATA; reset leaves it intact.
  always_ff @(posedge CLK) begin
    if (WE) rom[WADDR] <= WDATA;
  end

  assign word = rom[{state_q, x_s2}];

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_s1   <= '0;
      x_s2   <= '0;
      pbc_s1 <= 1'b0;
      pbc_s2 <= 1'b0;
      pbc_s3 <= 1'b0;
    end else begin
      x_s1   <= X;
      x_s2   <= x_s1;
      pbc_s1 <= PBC;
      pbc_s2 <= pbc_s1;
      pbc_s3 <= pbc_s2;
    end
  end

  assign pbc_edge = pbc_s2 & ~pbc_s3;

  always_ff @(posedge CLK) begin
    if (RST || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

  assign tick    = (cnt == PW'(DIV - 1));
  assign step    = tick & (MODE | pending);
  assign illegal = (int'(state_q) >= NUM_STATES);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_W'(RESET_STATE);
      z_q      <= '0;
      err_q    <= 1'b0;
      tick_led <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (tick) tick_led <= ~tick_led;
      // A press landing on the consuming tick re-arms pending so it is not lost.
      if (step)          pending <= pbc_edge;
      else if (pbc_edge) pending <= 1'b1;
      if (step) begin
        if (illegal) begin
          state_q <= ST_W'(RESET_STATE);
          z_q     <= '0;
          err_q   <= 1'b1;
        end else begin
          state_q <= word[ST_W-1:0];
          z_q     <= word[DW-1:ST_W];
        end
      end
    end
  end

  assign st_ext = {4'b0000, state_q};
  assign nib    = (st_ext > (ST_W + 4)'(15)) ? 4'hF : st_ext[3:0];

  seg7_hex_decoder u_seg (
    .clk (CLK),
    .hex (nib),
    .seg (SSEG_CA)
  );

  assign STATE    = state_q;
  assign Z        = z_q;
  assign ERR      = err_q;
  assign TICK_LED = tick_led;
  assign SSEG_AN  = 8'hFE;

endmodule
